bsg_manycore_host_packet_serdes: RTL and testbench

BSG_MANYCORE_HOST_PACKET_SERDES -- requirements
Module: bsg_manycore_host_packet_serdes

---
 rtl/bsg_manycore_host_packet_serdes.sv | 152 +++++++++++++++
 tb/tb_bsg_manycore_host_packet_serdes.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_manycore_host_packet_serdes.sv
// Host word <-> manycore packet serdes.
// Packs four TX host words per packet; unpacks RX packets into host words.
module bsg_manycore_host_packet_serdes #(
  parameter int host_width_p = 32,
  parameter int fifo_width_p = 128,
  parameter int tx_els_p = 4,
  parameter int rx_els_p = 4,
  parameter int rcv_th_p = 2,
  localparam int tx_vac_w = $clog2(4*tx_els_p+1),
  localparam int rx_occ_w = $clog2(4*rx_els_p+1)
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic host_v_i,
  input  logic [host_width_p-1:0] host_data_i,
  output logic host_ready_o,
  output logic pkt_v_o,
  output logic [fifo_width_p-1:0] pkt_data_o,
  input  logic pkt_ready_i,
  input  logic pkt_v_i,
  input  logic [fifo_width_p-1:0] pkt_data_i,
  output logic pkt_ready_o,
  output logic host_v_o,
  output logic [host_width_p-1:0] host_data_o,
  input  logic host_yumi_i,
  output logic [tx_vac_w-1:0] tx_vacancy_o,
  output logic [rx_occ_w-1:0] rx_occupancy_o,
  output logic rcv_fifo_th_o
);

  localparam int tx_pw = (tx_els_p > 1) ? $clog2(tx_els_p) : 1;
  localparam int rx_pw = (rx_els_p > 1) ? $clog2(rx_els_p) : 1;
  localparam int tx_cw = $clog2(tx_els_p+1);
  localparam int rx_cw = $clog2(rx_els_p+1);

  // TX side state
  logic [1:0] tx_cnt_r;
  logic [3*host_width_p-1:0] pack_r;
  logic [fifo_width_p-1:0] tx_mem [tx_els_p];
  logic [tx_pw-1:0] tx_wr_r, tx_rd_r;
  logic [tx_cw-1:0] tx_count_r;
  logic tx_full, host_fire, tx_push, tx_pop;

  // RX side state
  logic [1:0] rx_cnt_r;
  logic [fifo_width_p-1:0] rx_mem [rx_els_p];
  logic [rx_pw-1:0] rx_wr_r, rx_rd_r;
  logic [rx_cw-1:0] rx_count_r;
  logic [fifo_width_p-1:0] rx_head;
  logic rx_full, rx_push, rx_pop, host_take;

  int tx_free;
  int rx_used;

  assign tx_full = tx_count_r == tx_cw'(tx_els_p);
  assign host_ready_o = (tx_cnt_r != 2'd3) | ~tx_full;
  assign host_fire = host_v_i & host_ready_o;
  assign tx_push = host_fire & (tx_cnt_r == 2'd3);
  assign pkt_v_o = tx_count_r != '0;
  assign tx_pop = pkt_v_o & pkt_ready_i;
  assign pkt_data_o = tx_mem[tx_rd_r];

  // A head pop this cycle frees a slot, so a full RX FIFO may still
  // take a packet in the same cycle.
  assign rx_full = rx_count_r == rx_cw'(rx_els_p);
  assign host_v_o = rx_count_r != '0;
  assign host_take = host_yumi_i & host_v_o;
  assign rx_pop = host_take & (rx_cnt_r == 2'd3);
  assign pkt_ready_o = ~rx_full | rx_pop;
  assign rx_push = pkt_v_i & pkt_ready_o;
  assign rx_head = rx_mem[rx_rd_r];

  // Pack words 0..2; word 3 goes straight into the FIFO with them
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < 3; k++)
      if (host_fire && tx_cnt_r == 2'(k))
        pack_r[k*host_width_p +: host_width_p] <= host_data_i;
    if (tx_push)
      tx_mem[tx_wr_r] <= {host_data_i, pack_r};
    if (rx_push)
      rx_mem[rx_wr_r] <= pkt_data_i;
  end

  // TX slot counter, FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_cnt_r <= '0;
      tx_wr_r <= '0;
      tx_rd_r <= '0;
      tx_count_r <= '0;
    end else begin
      if (host_fire)
        tx_cnt_r <= tx_cnt_r + 2'd1;
      if (tx_push)
        tx_wr_r <= (tx_wr_r == tx_pw'(tx_els_p-1))
                 ? '0 : tx_wr_r + tx_pw'(1);
      if (tx_pop)
        tx_rd_r <= (tx_rd_r == tx_pw'(tx_els_p-1))
                 ? '0 : tx_rd_r + tx_pw'(1);
      if (tx_push && !tx_pop)
        tx_count_r <= tx_count_r + tx_cw'(1);
      else if (!tx_push && tx_pop)
        tx_count_r <= tx_count_r - tx_cw'(1);
    end
  end

  // RX word index, FIFO pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_cnt_r <= '0;
      rx_wr_r <= '0;
      rx_rd_r <= '0;
      rx_count_r <= '0;
    end else begin
      if (host_take)
        rx_cnt_r <= rx_cnt_r + 2'd1;
      if (rx_push)
        rx_wr_r <= (rx_wr_r == rx_pw'(rx_els_p-1))
                 ? '0 : rx_wr_r + rx_pw'(1);
      if (rx_pop)
        rx_rd_r <= (rx_rd_r == rx_pw'(rx_els_p-1))
                 ? '0 : rx_rd_r + rx_pw'(1);
      if (rx_push && !rx_pop)
        rx_count_r <= rx_count_r + rx_cw'(1);
      else if (!rx_push && rx_pop)
        rx_count_r <= rx_count_r - rx_cw'(1);
    end
  end

  // Word select from the RX head packet
  always_comb begin
    host_data_o = '0;
    for (int k = 0; k < 4; k++)
      if (rx_cnt_r == 2'(k))
        host_data_o = rx_head[k*host_width_p +: host_width_p];
  end

  // Status from registered state; vacancy floors at zero while
  // the pack register holds words beyond a full FIFO.
  always_comb begin
    tx_free = 4*(tx_els_p - int'(tx_count_r)) - int'(tx_cnt_r);
    rx_used = 4*int'(rx_count_r) - int'(rx_cnt_r);
    tx_vacancy_o = (tx_free < 0) ? '0 : tx_vac_w'(tx_free);
    rx_occupancy_o = rx_occ_w'(rx_used);
    rcv_fifo_th_o = (rx_els_p - int'(rx_count_r)) < rcv_th_p;
  end

  yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (reset_i)
    host_yumi_i |-> host_v_o);

endmodule

// File: tb/tb_bsg_manycore_host_packet_serdes.sv
// Directed bench for bsg_manycore_host_packet_serdes.
// Default parameters: 32-bit words, 4-deep FIFOs, threshold 2.
module tb_bsg_manycore_host_packet_serdes;

  logic clk_i = 0;
  logic reset_i;
  logic host_v_i;
  logic [31:0] host_data_i;
  logic host_ready_o;
  logic pkt_v_o;
  logic [127:0] pkt_data_o;
  logic pkt_ready_i;
  logic pkt_v_i;
  logic [127:0] pkt_data_i;
  logic pkt_ready_o;
  logic host_v_o;
  logic [31:0] host_data_o;
  logic host_yumi_i;
  logic [4:0] tx_vacancy_o;
  logic [4:0] rx_occupancy_o;
  logic rcv_fifo_th_o;

  int checks = 0;
  int errors = 0;
  logic [127:0] rxq [$];

  always #5 clk_i = ~clk_i;

  bsg_manycore_host_packet_serdes dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .host_v_i(host_v_i),
    .host_data_i(host_data_i),
    .host_ready_o(host_ready_o),
    .pkt_v_o(pkt_v_o),
    .pkt_data_o(pkt_data_o),
    .pkt_ready_i(pkt_ready_i),
    .pkt_v_i(pkt_v_i),
    .pkt_data_i(pkt_data_i),
    .pkt_ready_o(pkt_ready_o),
    .host_v_o(host_v_o),
    .host_data_o(host_data_o),
    .host_yumi_i(host_yumi_i),
    .tx_vacancy_o(tx_vacancy_o),
    .rx_occupancy_o(rx_occupancy_o),
    .rcv_fifo_th_o(rcv_fifo_th_o)
  );

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] tw(input int i);
    return 32'h0000_0100 + 32'(i);
  endfunction

  function automatic logic [127:0] rp(input int n);
    logic [127:0] p;
    for (int k = 0; k < 4; k++)
      p[32*k +: 32] = 32'h5000_0000 + 32'(n*16 + k);
    return p;
  endfunction

  task automatic send_word(input logic [31:0] d);
    int n;
    n = 0;
    host_v_i = 1;
    host_data_i = d;
    while (!host_ready_o && n < 50) begin
      step();
      n++;
    end
    check("send_timeout", 128'(n < 50), 128'(1));
    step();
    host_v_i = 0;
  endtask

  task automatic pop_pkt(input logic [127:0] exp);
    check("pkt_v", 128'(pkt_v_o), 128'(1));
    check("pkt_data", pkt_data_o, exp);
    pkt_ready_i = 1;
    step();
    pkt_ready_i = 0;
  endtask

  task automatic push_rx(input logic [127:0] p);
    check("rx_ready", 128'(pkt_ready_o), 128'(1));
    pkt_v_i = 1;
    pkt_data_i = p;
    step();
    pkt_v_i = 0;
    rxq.push_back(p);
  endtask

  task automatic read_word(input int k);
    check("host_v", 128'(host_v_o), 128'(1));
    check("host_data", 128'(host_data_o),
          128'(rxq[0][32*k +: 32]));
    host_yumi_i = 1;
    step();
    host_yumi_i = 0;
    if (k == 3) void'(rxq.pop_front());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    reset_i = 1;
    host_v_i = 0;
    host_data_i = '0;
    pkt_ready_i = 0;
    pkt_v_i = 0;
    pkt_data_i = '0;
    host_yumi_i = 0;
    step();
    step();
    check("rst_host_ready", 128'(host_ready_o), 128'(1));
    check("rst_pkt_v", 128'(pkt_v_o), 128'(0));
    check("rst_pkt_ready", 128'(pkt_ready_o), 128'(1));
    check("rst_host_v", 128'(host_v_o), 128'(0));
    check("rst_tx_vac", 128'(tx_vacancy_o), 128'(16));
    check("rst_rx_occ", 128'(rx_occupancy_o), 128'(0));
    check("rst_th", 128'(rcv_fifo_th_o), 128'(0));
    reset_i = 0;
    step();

    // basic pack, vacancy 16 -> 15 -> 14 -> 13 -> 12
    send_word(32'h1111_1111);
    check("vac1", 128'(tx_vacancy_o), 128'(15));
    check("nopkt", 128'(pkt_v_o), 128'(0));
    send_word(32'h2222_2222);
    check("vac2", 128'(tx_vacancy_o), 128'(14));
    send_word(32'h3333_3333);
    check("vac3", 128'(tx_vacancy_o), 128'(13));
    send_word(32'h4444_4444);
    check("vac4", 128'(tx_vacancy_o), 128'(12));
    pop_pkt({32'h4444_4444, 32'h3333_3333,
             32'h2222_2222, 32'h1111_1111});
    check("tx_empty", 128'(pkt_v_o), 128'(0));
    check("vac_back", 128'(tx_vacancy_o), 128'(16));

    // TX full back-pressure
    for (int i = 0; i < 16; i++) send_word(tw(i));
    check("full_vac", 128'(tx_vacancy_o), 128'(0));
    for (int i = 16; i < 19; i++) begin
      check("pre_stall_rdy", 128'(host_ready_o), 128'(1));
      send_word(tw(i));
    end
    host_v_i = 1;
    host_data_i = tw(19);
    check("stall_rdy", 128'(host_ready_o), 128'(0));
    step();
    step();
    check("stall_rdy2", 128'(host_ready_o), 128'(0));
    check("stall_vac", 128'(tx_vacancy_o), 128'(0));
    pop_pkt({tw(3), tw(2), tw(1), tw(0)});
    check("unstall_rdy", 128'(host_ready_o), 128'(1));
    step();
    host_v_i = 0;
    check("refill_vac", 128'(tx_vacancy_o), 128'(0));
    for (int p = 1; p < 5; p++)
      pop_pkt({tw(4*p+3), tw(4*p+2), tw(4*p+1), tw(4*p)});
    check("drain_vac", 128'(tx_vacancy_o), 128'(16));

    // RX unpack order and occupancy 4,3,2,1,0
    push_rx({32'hDDDD_DDDD, 32'hCCCC_CCCC,
             32'hBBBB_BBBB, 32'hAAAA_AAAA});
    for (int k = 0; k < 4; k++) begin
      check("rx_occ", 128'(rx_occupancy_o), 128'(4 - k));
      read_word(k);
    end
    check("rx_occ0", 128'(rx_occupancy_o), 128'(0));
    check("rx_empty", 128'(host_v_o), 128'(0));

    // threshold: rises after 3rd packet, drops after one pop
    push_rx(rp(0));
    push_rx(rp(1));
    check("th_2pkt", 128'(rcv_fifo_th_o), 128'(0));
    push_rx(rp(2));
    check("th_3pkt", 128'(rcv_fifo_th_o), 128'(1));
    for (int k = 0; k < 4; k++) read_word(k);
    check("th_pop", 128'(rcv_fifo_th_o), 128'(0));
    check("occ_8", 128'(rx_occupancy_o), 128'(8));

    // full RX: pop and push in the same cycle
    push_rx(rp(3));
    push_rx(rp(4));
    check("rx_full_rdy", 128'(pkt_ready_o), 128'(0));
    for (int k = 0; k < 3; k++) read_word(k);
    check("occ_13", 128'(rx_occupancy_o), 128'(13));
    host_yumi_i = 1;
    pkt_v_i = 1;
    pkt_data_i = rp(5);
    check("bypass_rdy", 128'(pkt_ready_o), 128'(1));
    step();
    host_yumi_i = 0;
    pkt_v_i = 0;
    void'(rxq.pop_front());
    rxq.push_back(rp(5));
    check("occ_16", 128'(rx_occupancy_o), 128'(16));
    check("full_again", 128'(pkt_ready_o), 128'(0));
    check("head_w0", 128'(host_data_o), 128'(rp(2)[31:0]));
    for (int p = 0; p < 4; p++)
      for (int k = 0; k < 4; k++) read_word(k);
    check("rx_drained", 128'(host_v_o), 128'(0));

    // reset mid-packing drops partial words
    send_word(32'hDEAD_0000);
    send_word(32'hDEAD_0001);
    reset_i = 1;
    step();
    reset_i = 0;
    check("rst_mid_vac", 128'(tx_vacancy_o), 128'(16));
    send_word(32'h0A0A_0000);
    send_word(32'h0A0A_0001);
    send_word(32'h0A0A_0002);
    send_word(32'h0A0A_0003);
    pop_pkt({32'h0A0A_0003, 32'h0A0A_0002,
             32'h0A0A_0001, 32'h0A0A_0000});

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
